// File: rtl/demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl
//
// Scheduler in front of the three decryption channels. Incoming ciphertext
// words are tagged with a destination channel and queued in a small word
// FIFO. A two-state FSM pops one word at a time and serializes it, most
// significant byte first, onto the selected channel with a valid/ready
// handshake. Words tagged with channel 3 are discarded and counted.
//
// Ports:
//   clk_sys       system clock, rising edge
//   rst_n         synchronous active-low reset
//   word_i        input ciphertext word (MST_DWIDTH)
//   sel_i         destination channel for word_i (3 = invalid, dropped)
//   valid_i       word_i/sel_i valid
//   ready_o       FIFO can accept a word (combinational, !full)
//   chN_data_o    channel N byte (registered, N = 0..2)
//   chN_valid_o   channel N byte valid (registered)
//   chN_ready_i   channel N accepts the byte
//   busy_o        FSM sending or FIFO holding words
//   fifo_level_o  number of words stored in the FIFO
//   drop_cnt_o    saturating count of words dropped with sel = 3
// ---------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic [MST_DWIDTH-1:0]         word_i,
    input  logic [1:0]                    sel_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [SYS_DWIDTH-1:0]         ch0_data_o,
    output logic [SYS_DWIDTH-1:0]         ch1_data_o,
    output logic [SYS_DWIDTH-1:0]         ch2_data_o,
    output logic                          ch0_valid_o,
    output logic                          ch1_valid_o,
    output logic                          ch2_valid_o,
    input  logic                          ch0_ready_i,
    input  logic                          ch1_ready_i,
    input  logic                          ch2_ready_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int NUM_BYTES = MST_DWIDTH / SYS_DWIDTH;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int ENTRY_W   = MST_DWIDTH + 2;

    localparam logic [1:0] SEL_DROP = 2'd3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    // Word FIFO storage and bookkeeping
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    head;
    logic [1:0]            head_sel;
    logic [MST_DWIDTH-1:0] head_word;

    // Serializer state
    logic [0:0]            state_q;
    logic [MST_DWIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            cur_sel_q;
    logic [7:0]            drop_cnt_q;
    logic [SYS_DWIDTH-1:0] ch_data_q [3];
    logic [2:0]            ch_valid_q;
    logic [2:0]            ch_ready;
    logic                  sel_ready;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign push       = valid_i && !fifo_full;
    // Only an idle FSM pops; the head is registered storage, so a word pushed
    // into an empty FIFO is always popped on a later edge.
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    assign head      = fifo_mem[rd_ptr_q];
    assign head_sel  = head[ENTRY_W-1 -: 2];
    assign head_word = head[MST_DWIDTH-1:0];

    assign ch_ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

    // Only the ready of the channel currently being served matters.
    always_comb begin
        sel_ready = 1'b0;
        case (cur_sel_q)
            2'd0:    sel_ready = ch_ready[0];
            2'd1:    sel_ready = ch_ready[1];
            2'd2:    sel_ready = ch_ready[2];
            default: sel_ready = 1'b0;
        endcase
    end

    // Storage array carries no reset; the level counter alone defines validity.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {sel_i, word_i};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // shift_q holds the bytes still to be sent, left aligned, so the next
    // byte is always its top slice.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            cur_sel_q  <= '0;
            drop_cnt_q <= '0;
            ch_valid_q <= '0;
            for (int c = 0; c < 3; c++) begin
                ch_data_q[c] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (head_sel == SEL_DROP) begin
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end else begin
                            shift_q   <= head_word << SYS_DWIDTH;
                            idx_q     <= IDX_W'(NUM_BYTES - 1);
                            cur_sel_q <= head_sel;
                            for (int c = 0; c < 3; c++) begin
                                if (head_sel == 2'(c)) begin
                                    ch_data_q[c]  <= head_word[MST_DWIDTH-1 -: SYS_DWIDTH];
                                    ch_valid_q[c] <= 1'b1;
                                end
                            end
                            state_q <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (sel_ready) begin
                        if (idx_q != '0) begin
                            shift_q <= shift_q << SYS_DWIDTH;
                            idx_q   <= idx_q - IDX_W'(1);
                            for (int c = 0; c < 3; c++) begin
                                if (cur_sel_q == 2'(c)) begin
                                    ch_data_q[c] <= shift_q[MST_DWIDTH-1 -: SYS_DWIDTH];
                                end
                            end
                        end else begin
                            ch_valid_q <= '0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign ready_o      = !fifo_full;
    assign busy_o       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_level_o = level_q;
    assign drop_cnt_o   = drop_cnt_q;

    assign ch0_data_o  = ch_data_q[0];
    assign ch1_data_o  = ch_data_q[1];
    assign ch2_data_o  = ch_data_q[2];
    assign ch0_valid_o = ch_valid_q[0];
    assign ch1_valid_o = ch_valid_q[1];
    assign ch2_valid_o = ch_valid_q[2];

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Scheduler in front of the three decryption channels (channel 0, 1, 2).
- Accepts master-width ciphertext words tagged with a channel select and buffers them in a small word FIFO.
- Serializes each word into system-width bytes, most-significant byte first, onto the selected channel using a valid/ready handshake per channel.
- Removes the fixed-timing assumptions of the plain demux: words queue under backpressure instead of being lost.

Parameters:
- MST_DWIDTH, 32, input word width; must be an integer multiple of SYS_DWIDTH.
- SYS_DWIDTH, 8, output byte width per channel.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, at least 2.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- word_i  in  MST_DWIDTH  input ciphertext word.
- sel_i  in  2  destination channel for word_i; 3 = invalid.
- valid_i  in  1  word_i/sel_i valid.
- ready_o  out  1  FIFO can accept a word; combinational, equal to !full.
- ch0_data_o / ch1_data_o / ch2_data_o  out  SYS_DWIDTH  channel byte, registered.
- ch0_valid_o / ch1_valid_o / ch2_valid_o  out  1  channel byte valid, registered.
- ch0_ready_i / ch1_ready_i / ch2_ready_i  in  1  channel accepts the byte.
- busy_o  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  stored word count.
- drop_cnt_o  out  8  saturating count of words dropped with sel=3.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO is emptied and level = 0.
  - FSM goes to IDLE.
  - All chN_valid_o = 0, all chN_data_o = 0, drop_cnt_o = 0.
  - ready_o = 1 after reset.
  - A reset mid-transfer aborts the current word; the remaining bytes are never emitted.
- Push: valid_i & ready_o at an edge writes {sel_i, word_i} to the FIFO.
  - When full, ready_o = 0 and valid_i is ignored (no overwrite).
- The FIFO uses a wrapping write/read pointer pair plus a level counter.
  - A push and a pop in the same cycle leave the level unchanged.
- FSM states:
  - IDLE:
    - If the FIFO is not empty, pop the head.
    - If the head has sel ≠ 3: load the word into the shift register, byte index = MST_DWIDTH/SYS_DWIDTH − 1, drive ch[sel]_data_o with the top byte, set ch[sel]_valid_o = 1, and go to SEND.
    - If the head has sel = 3: discard it, increment drop_cnt_o (saturates at 255), and stay in IDLE.
  - SEND:
    - Exactly one chN_valid_o is high. Data and valid are held stable while ch[sel]_ready_i = 0.
    - On ch[sel]_valid_o & ch[sel]_ready_i with byte index > 0: present the next lower byte on the following cycle and decrement the index.
    - On the handshake with byte index = 0: deassert valid and return to IDLE.
    - ready_i of non-selected channels is ignored.
- Latency:
  - A word accepted at edge t is popped at edge t+1.
  - Its first byte is valid after edge t+1, i.e. during cycle t+2.
  - With ready held high, bytes follow on consecutive cycles.
  - There is one idle cycle between consecutive words.
- Byte order: for 32/8, bytes are word[31:24], [23:16], [15:8], [7:0].
- Non-selected channels keep valid = 0. Their data outputs hold their last value.
- Simultaneous events:
  - Push while the FIFO is full: not accepted.
  - Push into an empty FIFO while the FSM is in IDLE: pop occurs on the next edge, never the same edge.
  - A pop in IDLE and a push at the same edge are both performed.

Test Plan:
- Single word, sel_i=1, 0xA1B2C3D4, all ready=1 → ch1_data_o = A1, B2, C3, D4 on 4 consecutive cycles starting 2 cycles after acceptance; ch0/ch2 valid stay 0; busy_o then returns to 0.
- Backpressure: sel_i=0, 0x11223344, ch0_ready_i low for 3 cycles while 0x22 is presented → 0x22 held with valid high for 4 cycles total; sequence completes 11, 22, 33, 44 with no duplicates.
- FIFO full: all ready_i=0, offer 6 words with sel=2 back-to-back → first word enters SEND and 4 more fill the FIFO; fifo_level_o = 4, ready_o = 0, 6th word not accepted; releasing ch2_ready_i drains 5 words (20 bytes) in order.
- Drop: words with sel=3, 0xDEADBEEF, then sel=2, 0x01020304 → drop_cnt_o = 1, no channel valid for the first word; ch2 emits 01, 02, 03, 04. With 256 dropped words, drop_cnt_o saturates at 255.
- Interleaved selects 0, 1, 2, 0 → each channel receives only its own bytes in MSB-first order, and channel valids are never high simultaneously.
- Reset mid-SEND after 2 bytes, with 2 words queued → all valids 0, fifo_level_o = 0, ready_o = 1 on the cycle after reset; no further bytes from the aborted words.
